// File: rtl/rv32_pkg.sv
// Shared RV32 types and constants for the execute-stage divide/remainder unit.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // Encoding matches funct3[1:0] of the M-extension divide group.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; the result and rd
// feed the register-file write port. Divide-by-zero and INT_MIN/-1 bypass the loop.
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            wr_en,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result,
  output logic [1:0]      state_dbg
);
  import rv32_pkg::*;

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  // Handshake: start is sampled only while busy is low (IDLE); a request seen
  // while busy is dropped, never queued. done pulses for one cycle, and wr_en
  // qualifies it for the register file (no write to x0).

  logic [1:0]      state;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic            sign_a_q;
  logic            sign_b_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] rem_q;
  logic [CNT_W-1:0] cnt;

  // One restoring step; returns {next remainder, next dividend/quotient shift reg}.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] rem,
                                                 input logic [XLEN-1:0] dvd,
                                                 input logic [XLEN-1:0] dvs);
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_n;
    logic            q_bit;
    shifted = {rem, dvd[XLEN-1]};
    trial   = shifted - {1'b0, dvs};
    q_bit   = ~trial[XLEN];
    rem_n   = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    return {rem_n, dvd[XLEN-2:0], q_bit};
  endfunction

  function automatic logic [XLEN-1:0] sign_fix(input logic [1:0]      f_op,
                                               input logic [XLEN-1:0] q,
                                               input logic [XLEN-1:0] r,
                                               input logic            sa,
                                               input logic            sb);
    logic [XLEN-1:0] res;
    case (f_op)
      DIV:     res = (sa ^ sb) ? (~q + 1'b1) : q;
      DIVU:    res = q;
      REM:     res = sa ? (~r + 1'b1) : r;
      default: res = r;
    endcase
    return res;
  endfunction

  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] dvd_nxt;
  logic [XLEN-1:0] fixed;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & rs1_data[XLEN-1];
    b_neg     = signed_op & rs2_data[XLEN-1];
    mag_a     = a_neg ? (~rs1_data + 1'b1) : rs1_data;
    mag_b     = b_neg ? (~rs2_data + 1'b1) : rs2_data;
    div_zero  = (rs2_data == '0);
    ovf       = signed_op && (rs1_data == INT_MIN) && (rs2_data == '1);
    {rem_nxt, dvd_nxt} = div_step(rem_q, dvd_q, dvs_q);
    fixed     = sign_fix(op_q, dvd_nxt, rem_nxt, sign_a_q, sign_b_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt      <= '0;
      result   <= '0;
      rd_out   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            op_q     <= op;
            rd_q     <= rd_in;
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            dvd_q    <= mag_a;
            dvs_q    <= mag_b;
            rem_q    <= '0;
            cnt      <= '0;
            if (div_zero) begin
              result <= op[1] ? rs1_data : DIV_ZERO_Q;
              rd_out <= rd_in;
              state  <= ST_DONE;
            end else if (ovf) begin
              result <= op[1] ? '0 : INT_MIN;
              rd_out <= rd_in;
              state  <= ST_DONE;
            end else begin
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            rem_q <= rem_nxt;
            dvd_q <= dvd_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_W'(XLEN - 1)) begin
              result <= fixed;
              rd_out <= rd_q;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE) && !flush;
  assign wr_en     = done && (rd_out != 5'd0);
  assign state_dbg = state;

endmodule
